// File: rtl/ccu_mem_sched_pkg.sv
// ============================================================================
// Module      : ccu_mem_sched_pkg
// Description : Shared constants, line-address type and line extraction helper
//               for the CCU memory-request hazard scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccu_mem_sched_pkg;

    localparam int unsigned C_ADDR_WIDTH  = 64;
    localparam int unsigned C_LINE_OFFSET = 6;
    localparam int unsigned C_LINE_WIDTH  = C_ADDR_WIDTH - C_LINE_OFFSET;

    typedef logic [C_LINE_WIDTH-1:0] line_t;

    // Caller truncates the result to its own line width.
    function automatic logic [C_ADDR_WIDTH-1:0] line_of(
        input logic [C_ADDR_WIDTH-1:0] addr,
        input int unsigned             offset
    );
        return addr >> offset;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccu_mem_sched_wb_line_table.sv
// ============================================================================
// Module      : ccu_wb_line_table
// Description : In-order circular table of in-flight write-back line addresses
//               with a parallel compare port against one queried line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_wb_line_table #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 58
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [LINE_W-1:0]       i_push_line,
    input  logic                    i_pop,
    input  logic [LINE_W-1:0]       i_query_line,
    output logic                    o_match,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [LINE_W-1:0] r_line [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_pop;

    // A B response with nothing outstanding (e.g. straddling a reset) is dropped.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            // Push after pop so a full-table push/pop on the same slot keeps the new entry.
            if (i_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_line[r_wr_ptr] <= i_push_line;
        end
    end

    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_line[i] == i_query_line)) begin
                o_match = 1'b1;
            end
        end
    end

    assign o_count = r_count;

    a_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_count == '0)));

endmodule

`default_nettype wire

// File: rtl/ccu_mem_sched.sv
// ============================================================================
// Module      : ccu_mem_sched
// Description : Read/write-back hazard and throughput scheduler in front of the
//               memory controller AW/AR request inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_mem_sched
    import ccu_mem_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter int LINE_OFFSET = C_LINE_OFFSET,
    parameter int WB_DEPTH    = 4,
    parameter int MAX_READS   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    output logic                  wb_ready_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    input  logic                  ar_valid_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    output logic                  ar_ready_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    input  logic                  b_valid_i,
    input  logic                  b_ready_i,
    input  logic                  b_wb_i,
    input  logic                  r_valid_i,
    input  logic                  r_ready_i,
    input  logic                  r_last_i,
    output logic                  busy_o,
    output logic                  hazard_o
);

    localparam int LW = ADDR_WIDTH - LINE_OFFSET;
    localparam int CW = $clog2(MAX_READS + 1);
    localparam int PW = $clog2(WB_DEPTH);

    logic [LW-1:0] w_ar_line;
    logic [LW-1:0] w_wb_line;
    logic          w_tab_match;
    logic [PW:0]   w_wb_count;
    logic          w_ar_match;
    logic          w_wb_match;
    logic          w_ar_allow;
    logic          w_wb_allow;
    logic          w_wb_push;
    logic          w_b_pop;
    logic          w_ar_hs;
    logic          w_r_done;
    logic [CW-1:0] r_rd_cnt;
    logic          r_ar_lock;
    logic          r_wb_lock;

    assign w_ar_line = LW'(line_of(C_ADDR_WIDTH'(ar_addr_i), LINE_OFFSET));
    assign w_wb_line = LW'(line_of(C_ADDR_WIDTH'(wb_addr_i), LINE_OFFSET));

    assign w_wb_push = wb_valid_o && wb_ready_i;
    assign w_b_pop   = b_valid_i && b_ready_i && b_wb_i;
    assign w_ar_hs   = ar_valid_o && ar_ready_i;
    assign w_r_done  = r_valid_i && r_ready_i && r_last_i && (r_rd_cnt != '0);

    ccu_wb_line_table #(
        .DEPTH  (WB_DEPTH),
        .LINE_W (LW)
    ) u_table (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_push       (w_wb_push),
        .i_push_line  (w_wb_line),
        .i_pop        (w_b_pop),
        .i_query_line (w_ar_line),
        .o_match      (w_tab_match),
        .o_count      (w_wb_count)
    );

    // The wb_valid_i term makes a same-cycle WB win over an AR to the same line.
    assign w_ar_match = w_tab_match || (wb_valid_i && (w_wb_line == w_ar_line));
    assign w_wb_match = r_ar_lock && (w_ar_line == w_wb_line);

    assign w_ar_allow = r_ar_lock || (!w_ar_match && (r_rd_cnt != CW'(MAX_READS)));
    assign w_wb_allow = r_wb_lock || ((w_wb_count != (PW+1)'(WB_DEPTH)) && !w_wb_match);

    assign ar_valid_o = ar_valid_i && w_ar_allow;
    assign ar_ready_o = ar_ready_i && w_ar_allow;
    assign wb_valid_o = wb_valid_i && w_wb_allow;
    assign wb_ready_o = wb_ready_i && w_wb_allow;

    assign hazard_o = (ar_valid_i && !r_ar_lock && w_ar_match) ||
                      (wb_valid_i && !r_wb_lock && w_wb_match);

    assign busy_o = (w_wb_count != '0) || (r_rd_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_cnt  <= '0;
            r_ar_lock <= 1'b0;
            r_wb_lock <= 1'b0;
        end else begin
            case ({w_ar_hs, w_r_done})
                2'b10:   r_rd_cnt <= r_rd_cnt + CW'(1);
                2'b01:   r_rd_cnt <= r_rd_cnt - CW'(1);
                default: r_rd_cnt <= r_rd_cnt;
            endcase
            // A raised valid stays up until its handshake, whatever hazards appear.
            r_ar_lock <= ar_valid_o && !ar_ready_i;
            r_wb_lock <= wb_valid_o && !wb_ready_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ccu_mem_sched.sv
// ============================================================================
// Module      : tb_ccu_mem_sched
// Description : Directed and randomized self-checking bench for ccu_mem_sched
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccu_mem_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_valid_i, wb_ready_i, ar_valid_i, ar_ready_i;
    logic [63:0] wb_addr_i, ar_addr_i;
    logic        b_valid_i, b_ready_i, b_wb_i, r_valid_i, r_ready_i, r_last_i;
    logic        wb_ready_o, wb_valid_o, ar_ready_o, ar_valid_o, busy_o, hazard_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: in-order queue of pending write-back lines and a read counter.
    logic [57:0] q[$];
    int          rd_m;
    bit          arl_m, wbl_m, ar_hs_m, wb_hs_m;
    logic        e_arv, e_arr, e_wbv, e_wbr, e_haz, e_busy;

    always #5 clk = ~clk;

    ccu_mem_sched dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_valid_i (wb_valid_i),
        .wb_addr_i  (wb_addr_i),
        .wb_ready_o (wb_ready_o),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .ar_valid_i (ar_valid_i),
        .ar_addr_i  (ar_addr_i),
        .ar_ready_o (ar_ready_o),
        .ar_valid_o (ar_valid_o),
        .ar_ready_i (ar_ready_i),
        .b_valid_i  (b_valid_i),
        .b_ready_i  (b_ready_i),
        .b_wb_i     (b_wb_i),
        .r_valid_i  (r_valid_i),
        .r_ready_i  (r_ready_i),
        .r_last_i   (r_last_i),
        .busy_o     (busy_o),
        .hazard_o   (hazard_o)
    );

    function automatic logic [57:0] ln(input logic [63:0] a);
        return a[63:6];
    endfunction

    task automatic model_clear();
        q.delete();
        rd_m  = 0;
        arl_m = 0;
        wbl_m = 0;
    endtask

    task automatic model_eval();
        bit hit, arm, wbm, ar_ok, wb_ok;
        hit = 0;
        foreach (q[i]) if (q[i] == ln(ar_addr_i)) hit = 1;
        arm   = hit || (wb_valid_i && ln(wb_addr_i) == ln(ar_addr_i));
        wbm   = arl_m && (ln(ar_addr_i) == ln(wb_addr_i));
        ar_ok = arl_m || (!arm && rd_m < 8);
        wb_ok = wbl_m || (q.size() < 4 && !wbm);
        e_arv  = ar_valid_i && ar_ok;
        e_arr  = ar_ready_i && ar_ok;
        e_wbv  = wb_valid_i && wb_ok;
        e_wbr  = wb_ready_i && wb_ok;
        e_haz  = (ar_valid_i && !arl_m && arm) || (wb_valid_i && !wbl_m && wbm);
        e_busy = (q.size() != 0) || (rd_m != 0);
    endtask

    task automatic model_update();
        ar_hs_m = e_arv && ar_ready_i;
        wb_hs_m = e_wbv && wb_ready_i;
        if (rst_i) begin
            model_clear();
        end else begin
            if (b_valid_i && b_ready_i && b_wb_i && q.size() > 0) void'(q.pop_front());
            if (wb_hs_m) q.push_back(ln(wb_addr_i));
            rd_m  = rd_m + int'(ar_hs_m) - int'(r_valid_i && r_ready_i && r_last_i && rd_m > 0);
            arl_m = e_arv && !ar_ready_i;
            wbl_m = e_wbv && !wb_ready_i;
        end
    endtask

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Outputs checked 1 ns after the falling edge, when inputs have settled.
    task automatic settle(input string tag);
        #1;
        model_eval();
        check(tag, {ar_valid_o, ar_ready_o, wb_valid_o, wb_ready_o, hazard_o, busy_o},
                   {e_arv, e_arr, e_wbv, e_wbr, e_haz, e_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc(input string tag);
        settle(tag);
        tick();
    endtask

    task automatic b_pulse(input string tag);
        b_valid_i = 1; b_ready_i = 1; b_wb_i = 1;
        cyc(tag);
        b_valid_i = 0;
    endtask

    task automatic r_pulse(input string tag);
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
        cyc(tag);
        r_valid_i = 0;
    endtask

    function automatic logic [63:0] rand_addr();
        return 64'(32'h0001_0000 + $urandom_range(0, 5) * 64 + $urandom_range(0, 63));
    endfunction

    initial begin
        rst_i = 1;
        wb_valid_i = 0; wb_ready_i = 1; wb_addr_i = '0;
        ar_valid_i = 0; ar_ready_i = 1; ar_addr_i = '0;
        b_valid_i = 0; b_ready_i = 0; b_wb_i = 0;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
        model_clear();
        @(negedge clk);
        cyc("reset0");
        settle("reset1");
        check1("reset_busy", busy_o, 1'b0);
        tick();
        rst_i = 0;

        // WB then AR to the same 64 B line: AR held until the B handshake.
        wb_valid_i = 1; wb_addr_i = 64'h1000;
        cyc("t1_wb");
        wb_valid_i = 0; ar_valid_i = 1; ar_addr_i = 64'h1020;
        settle("t1_ar_block");
        check1("t1_hazard", hazard_o, 1'b1);
        check1("t1_arv", ar_valid_o, 1'b0);
        tick();
        cyc("t1_hold");
        b_pulse("t1_b");
        settle("t1_release");
        check1("t1_arv_rel", ar_valid_o, 1'b1);
        tick();
        ar_valid_i = 0;
        r_pulse("t1_r");

        // Same-cycle AR and WB to one line: WB wins.
        ar_valid_i = 1; ar_addr_i = 64'h2000; wb_valid_i = 1; wb_addr_i = 64'h2010;
        settle("t2_both");
        check1("t2_wbv", wb_valid_o, 1'b1);
        check1("t2_arv", ar_valid_o, 1'b0);
        tick();
        wb_valid_i = 0;
        cyc("t2_held");
        b_pulse("t2_b");
        settle("t2_release");
        check1("t2_arv_rel", ar_valid_o, 1'b1);
        tick();
        ar_valid_i = 0;
        r_pulse("t2_r");

        // Locked AR keeps priority over a later WB to its line.
        ar_valid_i = 1; ar_addr_i = 64'h3000; ar_ready_i = 0;
        for (int i = 0; i < 5; i++) cyc("t3_ar_wait");
        wb_valid_i = 1; wb_addr_i = 64'h3008;
        settle("t3_wb_block");
        check1("t3_arv", ar_valid_o, 1'b1);
        check1("t3_wbv", wb_valid_o, 1'b0);
        tick();
        ar_ready_i = 1;
        settle("t3_ar_hs");
        check1("t3_wbv_hs", wb_valid_o, 1'b0);
        tick();
        ar_valid_i = 0;
        settle("t3_wb_pass");
        check1("t3_wbv_pass", wb_valid_o, 1'b1);
        tick();
        wb_valid_i = 0;
        b_pulse("t3_b");
        r_pulse("t3_r");

        // Table full after four write-backs; pointer wrap on the fifth.
        for (int k = 0; k < 4; k++) begin
            wb_valid_i = 1; wb_addr_i = 64'h4000 + 64'(k * 64);
            cyc("t4_fill");
        end
        wb_addr_i = 64'h5000;
        settle("t4_full");
        check1("t4_wbr_full", wb_ready_o, 1'b0);
        tick();
        b_pulse("t4_pop");
        cyc("t4_push5");
        wb_valid_i = 0; ar_valid_i = 1; ar_addr_i = 64'h5004;
        settle("t4_wrap_hit");
        check1("t4_wrap_haz", hazard_o, 1'b1);
        tick();
        ar_valid_i = 0;
        for (int k = 0; k < 4; k++) b_pulse("t4_drain");

        // Read cap.
        for (int k = 0; k < 8; k++) begin
            ar_valid_i = 1; ar_addr_i = 64'h8000 + 64'(k * 64);
            cyc("t5_fill");
        end
        ar_addr_i = 64'h9000;
        settle("t5_cap");
        check1("t5_arr_cap", ar_ready_o, 1'b0);
        tick();
        r_pulse("t5_rlast");
        cyc("t5_pass9");
        ar_valid_i = 0;
        for (int k = 0; k < 3; k++) r_pulse("t5_drain");

        // Reset with entries and reads outstanding.
        for (int k = 0; k < 3; k++) begin
            wb_valid_i = 1; wb_addr_i = 64'h6000 + 64'(k * 64);
            cyc("t6_fill");
        end
        wb_valid_i = 0; ar_valid_i = 1; ar_addr_i = 64'h6000;
        settle("t6_block");
        check1("t6_busy", busy_o, 1'b1);
        rst_i = 1;
        model_clear();
        settle("t6_in_reset");
        check1("t6_busy_rst", busy_o, 1'b0);
        check1("t6_haz_rst", hazard_o, 1'b0);
        tick();
        rst_i = 0;
        settle("t6_after");
        check1("t6_arv_after", ar_valid_o, 1'b1);
        tick();
        ar_valid_i = 0;
        r_pulse("t6_r");

        // Randomized traffic with AXI-stable requesters.
        ar_hs_m = 0; wb_hs_m = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!ar_valid_i || ar_hs_m) begin
                ar_valid_i = ($urandom_range(0, 2) == 0);
                ar_addr_i  = rand_addr();
            end
            if (!wb_valid_i || wb_hs_m) begin
                wb_valid_i = ($urandom_range(0, 2) == 0);
                wb_addr_i  = rand_addr();
            end
            ar_ready_i = ($urandom_range(0, 3) != 0);
            wb_ready_i = ($urandom_range(0, 3) != 0);
            b_valid_i  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            b_ready_i  = ($urandom_range(0, 3) != 0);
            b_wb_i     = ($urandom_range(0, 4) != 0);
            r_valid_i  = (rd_m > 0) && ($urandom_range(0, 1) == 0);
            r_ready_i  = ($urandom_range(0, 3) != 0);
            r_last_i   = ($urandom_range(0, 1) == 0);
            rst_i      = ($urandom_range(0, 499) == 0);
            if (rst_i) model_clear();
            cyc("rand");
        end
        rst_i = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
